// File: rtl/sample_compressor_if.sv
`default_nettype none
// sample_compressor_if -- raw-sample input, compressed-word output and status bundle.
// Revision 1.0
interface sample_compressor_if #(
  parameter int WIDTH = 60
);
  logic [15:0]      sample;
  logic             sample_strobe;
  logic             sample_ready;
  logic             flush;
  logic [15:0]      out_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] index;
  logic             overflow;

  modport master (
    output sample, sample_strobe, flush, out_ready,
    input  sample_ready, out_data, out_valid, index, overflow
  );

  modport slave (
    input  sample, sample_strobe, flush, out_ready,
    output sample_ready, out_data, out_valid, index, overflow
  );
endinterface
`default_nettype wire

// File: rtl/sample_compressor.sv
`default_nettype none
// sample_compressor -- run-length compressor: a repeated pair is followed by a repeat count word.
// Revision 1.0
module sample_compressor #(
  parameter int WIDTH = 60
) (
  input  logic                clk,
  input  logic                rst_n,
  sample_compressor_if.slave  bus
);

  localparam logic [1:0]  S_FIRST   = 2'd0;
  localparam logic [1:0]  S_CMP     = 2'd1;
  localparam logic [1:0]  S_RUN     = 2'd2;
  localparam logic [15:0] C_RUN_SAT = 16'hFFFF;

  logic [1:0]       state_q, state_d, mid_state;
  logic [15:0]      last_q, last_d;
  logic [15:0]      count_q, count_d, mid_count;
  logic [WIDTH-1:0] index_q;
  logic             overflow_q;

  logic [15:0]      fifo_q [4];
  logic [1:0]       wr_ptr_q, rd_ptr_q;
  logic [2:0]       occ_q, occ_d;

  logic             w_ready, w_accept, w_flush, w_same, w_pop;
  logic [15:0]      w_cnt_inc;
  logic             push0, push1;
  logic [15:0]      word0, word1;
  logic [1:0]       w_npush;

  // Readiness uses registered occupancy so a worst-case double push always fits.
  assign w_ready   = (occ_q <= 3'd2);
  assign w_accept  = bus.sample_strobe && w_ready;
  assign w_flush   = bus.flush && w_ready;
  assign w_same    = (bus.sample == last_q);
  assign w_cnt_inc = count_q + 16'd1;
  assign w_pop     = (occ_q != 3'd0) && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FIRST;
      last_q  <= 16'd0;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    mid_state = state_q;
    mid_count = count_q;
    last_d    = last_q;
    if (w_accept) begin
      case (state_q)
        S_FIRST: begin
          mid_state = S_CMP;
          last_d    = bus.sample;
        end
        S_CMP: begin
          last_d = bus.sample;
          if (w_same) begin
            mid_state = S_RUN;
            mid_count = 16'd0;
          end
        end
        S_RUN: begin
          if (w_same) begin
            mid_count = (w_cnt_inc == C_RUN_SAT) ? 16'd0 : w_cnt_inc;
          end else begin
            last_d    = bus.sample;
            mid_state = S_CMP;
          end
        end
        default: mid_state = S_FIRST;
      endcase
    end
    state_d = mid_state;
    count_d = mid_count;
    // Flush closes a run that is still open after this cycle's sample.
    if (w_flush && (mid_state == S_RUN)) begin
      state_d = S_FIRST;
      count_d = 16'd0;
    end
  end

  always_comb begin
    push0 = 1'b0;
    push1 = 1'b0;
    word0 = 16'd0;
    word1 = 16'd0;
    if (w_accept) begin
      case (state_q)
        S_FIRST, S_CMP: begin
          push0 = 1'b1;
          word0 = bus.sample;
        end
        S_RUN: begin
          if (w_same) begin
            if (w_cnt_inc == C_RUN_SAT) begin
              push0 = 1'b1;
              word0 = C_RUN_SAT;
            end
          end else begin
            push0 = 1'b1;
            word0 = count_q;
            push1 = 1'b1;
            word1 = bus.sample;
          end
        end
        default: ;
      endcase
    end
    if (w_flush && (mid_state == S_RUN)) begin
      if (push0) begin
        push1 = 1'b1;
        word1 = mid_count;
      end else begin
        push0 = 1'b1;
        word0 = mid_count;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (w_accept)
        index_q <= index_q + {{(WIDTH-1){1'b0}}, 1'b1};
      if (bus.sample_strobe && !w_ready)
        overflow_q <= 1'b1;
    end
  end

  assign w_npush = {1'b0, push0} + {1'b0, push1};
  assign occ_d   = occ_q + {1'b0, w_npush} - {2'b00, w_pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      occ_q    <= 3'd0;
    end else begin
      wr_ptr_q <= wr_ptr_q + w_npush;
      rd_ptr_q <= rd_ptr_q + {1'b0, w_pop};
      occ_q    <= occ_d;
    end
  end

  // Pushes only ever land in free slots, so the head word stays put while stalled.
  always_ff @(posedge clk) begin
    if (push0)
      fifo_q[wr_ptr_q] <= word0;
    if (push1)
      fifo_q[wr_ptr_q + 2'd1] <= word1;
  end

  assign bus.sample_ready = w_ready;
  assign bus.out_valid    = (occ_q != 3'd0);
  assign bus.out_data     = fifo_q[rd_ptr_q];
  assign bus.index        = index_q;
  assign bus.overflow     = overflow_q;

endmodule
`default_nettype wire

// File: doc/sample_compressor.md
SAMPLE_COMPRESSOR -- requirements
Module: sample_compressor

Interface
REQ-001 SHALL have parameter: width, 60, bit width of raw-sample index counter.
REQ-002 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port: sample  input  16  raw sample word.
REQ-005 SHALL have port: sample_strobe  input  1  sample valid this cycle.
REQ-006 SHALL have port: sample_ready  output  1  block can accept a sample this cycle.
REQ-007 SHALL have port: flush  input  1  terminate any open run (single-cycle pulse).
REQ-008 SHALL have port: out_data  output  16  compressed word at FIFO head.
REQ-009 SHALL have port: out_valid  output  1  out_data valid.
REQ-010 SHALL have port: out_ready  input  1  sink accepts word; transfer when out_valid && out_ready.
REQ-011 SHALL have port: index  output  width  count of raw samples accepted since reset.
REQ-012 SHALL have port: overflow  output  1  sticky; sample_strobe seen while sample_ready=0.

Function
REQ-013 SHALL encode the stream so a scanner decoding {emit, compare, count} states reconstructs the raw sample count: two equal consecutive data words are followed by count words of additional repeats.
REQ-014 SHALL implement states S_FIRST, S_CMP, S_RUN plus registers last[15:0], count[15:0].
REQ-015 S_FIRST, accepted sample x: write x; last<=x; ->S_CMP.
REQ-016 S_CMP, accepted x: write x; last<=x; if x==last ->S_RUN with count<=0, else stay.
REQ-017 S_RUN, accepted x==last: if count+1==16'hFFFF write 16'hFFFF and count<=0, else count<=count+1; stay S_RUN.
REQ-018 S_RUN, accepted x!=last: write count then x (that order); last<=x; ->S_CMP.
REQ-019 flush without strobe: in S_RUN write count, ->S_FIRST; in S_FIRST/S_CMP no effect.
REQ-020 flush with accepted strobe: apply REQ-015..018 first; if resulting state is S_RUN, then also write resulting count and ->S_FIRST.
REQ-021 At most 2 words written per cycle; words written in one cycle enter FIFO in stated order.
REQ-022 Output SHALL be a 4-entry FIFO; a word written in cycle N is visible at out_data no earlier than N+1; FIFO order preserved.
REQ-023 Simultaneous FIFO pop and up to 2 pushes in one cycle SHALL be supported.
REQ-024 sample_ready SHALL be 1 iff FIFO free entries >= 2 (registered occupancy, pop this cycle not counted).
REQ-025 Sample accepted iff sample_strobe && sample_ready; accepted sample increments index by 1 (wraps modulo 2^width).
REQ-026 Strobe with sample_ready=0: sample dropped, no state/index change, overflow<=1 until reset.
REQ-027 flush SHALL be ignored (no state change) when sample_ready=0.
REQ-028 out_data SHALL hold stable while out_valid && !out_ready.

Reset
REQ-029 On rst_n low, asynchronously: state<=S_FIRST, count<=0, index<=0, overflow<=0, FIFO empty (out_valid=0, sample_ready=1); last and out_data don't-care.
REQ-030 Reset mid-run SHALL discard open run and buffered words; first post-reset sample handled per REQ-015.

Verification
REQ-031 Samples 5,7,9, out_ready=1 -> out 0x0005,0x0007,0x0009; index=3.
REQ-032 Samples 3,3,3,3,8 -> out 0x0003,0x0003,0x0002,0x0008; index=5.
REQ-033 Samples 3,3 then flush alone -> out 0x0003,0x0003,0x0000; state S_FIRST; next 3 emitted as data word.
REQ-034 A,A, then 65535 more A, then B (A=0x1234,B=0x0001) -> out 0x1234,0x1234,0xFFFF,0x0000,0x0001.
REQ-035 out_ready=0, samples 1,2,3,4 on consecutive cycles -> sample_ready 0 after third; 4 dropped, overflow=1, index=3; release out_ready -> out 1,2,3.
REQ-036 rst_n pulsed low during run of 7s (count=5) -> out_valid=0, index=0 immediately; samples 7,7 after reset -> out 0x0007,0x0007.
